imem_loader: RTL and testbench

- Boot-time writer for the core's byte-addressed instruction memory; replaces hierarchical preloading with a real load path.
- Receives a length-prefixed, checksummed byte stream over a valid/ready interface, assembles little-endian 32-bit words and issues one word write per instruction.
- Holds the core in reset until the image is loaded and verified.
- Sits between a host byte source (UART receiver or bench driver) and the instruction memory write port.

---
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed, XOR-checksummed byte image into instruction memory
// as little-endian words, holding the core in reset until the image is verified.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [15:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic [15:0]           n_full;

    assign xfer   = in_valid && in_ready_q;
    assign n_full = {in_data, n_q[7:0]};

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        asm_d       = asm_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            LEN0: if (xfer) begin
                n_d[7:0] = in_data;
                state_d  = LEN1;
            end
            LEN1: if (xfer) begin
                n_d     = n_full;
                state_d = ({14'd0, n_full, 2'b00} > 32'(MEM_BYTES)) ? ERR :
                          (n_full == 16'd0) ? CSUM : DATA;
            end
            DATA: if (xfer) begin
                asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                csum_d     = csum_q ^ in_data;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    state_d     = WRITE;
                    mem_addr_d  = ADDR_WIDTH'({word_cnt_q, 2'b00});
                    mem_wdata_d = asm_d;
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                state_d    = (word_cnt_d == n_q) ? CSUM : DATA;
            end
            CSUM: if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
            default: ;
        endcase
        // Outputs are registered from the next state so they line up with the state they describe.
        in_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA) || (state_d == CSUM);
        mem_we_d   = state_d == WRITE;
        done_d     = state_d == DONE;
        err_d      = state_d == ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LEN0;
            n_q         <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            asm_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            asm_q       <= asm_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst_n = done_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; a stream-level model predicts writes and final outcome,
// a monitor checks every write strobe against the expected queue.
module tb_imem_loader;
    typedef logic [7:0] bq_t[$];
    localparam int OUT_DONE = 0, OUT_ERR = 1, OUT_BUSY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, core_rst_n, done, err;
    logic [7:0] mem_addr;
    logic [31:0] mem_wdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    imem_loader #(.ADDR_WIDTH(8), .MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_we) begin
            chk("in_ready_in_write", 32'(in_ready), 32'd0);
            if (exp_a.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                chk("write_addr", 32'(mem_addr), exp_a.pop_front());
                chk("write_data", mem_wdata, exp_d.pop_front());
            end
        end
    end

    // Stream-level reference: writes, accepted byte count and final outcome.
    task automatic model(input bq_t s, output int cons, output int outc);
        int n;
        logic [7:0] x;
        n = int'(s[0]) + 256 * int'(s[1]);
        if (4 * n > 256) begin
            cons = 2;
            outc = OUT_ERR;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(32'(4 * i));
            exp_d.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
            for (int k = 0; k < 4; k++) x ^= s[2+4*i+k];
        end
        cons = 3 + 4 * n;
        outc = (s[2+4*n] == x) ? OUT_DONE : OUT_ERR;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_flags", {29'd0, core_rst_n, done, err}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic check_outcome(input int outc);
        chk("done", 32'(done), 32'(outc == OUT_DONE));
        chk("err", 32'(err), 32'(outc == OUT_ERR));
        chk("core_rst_n", 32'(core_rst_n), 32'(outc == OUT_DONE));
        chk("in_ready_after", 32'(in_ready), 32'(outc == OUT_BUSY));
    endtask

    task automatic run_stream(input bq_t s, input int stall_pct, input int exp_cons, input int outc);
        int cons = 0;
        for (int i = 0; i < s.size(); i++) begin
            int tries = 0;
            int cyc = 0;
            bit took = 0;
            while (!took && tries < 8 && cyc < 400) begin
                @(negedge clk);
                if (32'($urandom_range(99)) < 32'(stall_pct)) begin
                    in_valid = 1'b0;
                    in_data = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data = s[i];
                end
                #1;
                took = in_valid && in_ready;
                if (in_valid && !took) tries++;
                cyc++;
                @(posedge clk);
            end
            if (!took) break;
            cons++;
            if (cons == exp_cons) begin
                @(negedge clk);
                in_valid = 1'b0;
                check_outcome(outc);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bytes_consumed", 32'(cons), 32'(exp_cons));
    endtask

    task automatic do_test(input bq_t s, input int stall_pct);
        int cons, outc;
        model(s, cons, outc);
        run_stream(s, stall_pct, cons, outc);
        repeat (3) @(negedge clk);
        chk("pending_writes", 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        bq_t img, s;
        int r, n;
        logic [7:0] x;
        img = {8'h02, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};

        do_reset();
        do_test(img, 0);
        do_reset();
        s = img;
        s[10] = 8'hC1;
        do_test(s, 0);
        do_reset();
        do_test('{8'h41, 8'h00, 8'h11, 8'h22}, 0);
        do_reset();
        do_test('{8'h00, 8'h00, 8'h00}, 0);
        do_reset();
        do_test('{8'h00, 8'h00, 8'h05}, 0);
        do_reset();
        do_test(img, 50);

        do_reset();
        exp_a.push_back(32'h0);
        exp_d.push_back(32'h0000_7033);
        s = img[0:7];
        run_stream(s, 20, 8, OUT_BUSY);
        chk("pending_before_reset", 32'(exp_a.size()), 32'd0);
        do_reset();
        do_test(img, 20);

        for (int t = 0; t < 24; t++) begin
            r = int'($urandom_range(9));
            n = (r == 0) ? int'($urandom_range(65535, 65)) : (r == 1) ? 64 : int'($urandom_range(8));
            s = {};
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            x = 8'h00;
            if (n <= 64) begin
                for (int i = 0; i < 4 * n; i++) begin
                    s.push_back(8'($urandom));
                    x ^= s[s.size()-1];
                end
                s.push_back(($urandom_range(3) == 0) ? x ^ 8'(1 << $urandom_range(7)) : x);
            end
            for (int i = 0; i < int'($urandom_range(2)); i++) s.push_back(8'($urandom));
            do_reset();
            do_test(s, int'($urandom_range(60)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
